// File: rtl/riscv_pkg.sv
//==============================================================================
// riscv_pkg: shared fetch/decode constants, RV32I opcodes and a field helper.
// Revision: 1.0
//==============================================================================
`default_nettype none

package riscv_pkg;

   localparam int ADDR_W_DEF  = 8;
   localparam int INSTR_W_DEF = 32;
   localparam int PC_STEP_DEF = 4;
   localparam int CNT_W_DEF   = 16;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = 6;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   function automatic logic [6:0] opcode_of(input logic [31:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
//==============================================================================
// pc_reg: program counter with redirect/hold/increment next-pc selection,
// word alignment of redirect targets and misalignment pulse. Revision: 1.0
//==============================================================================
`default_nettype none

module pc_reg
   import riscv_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                PC_STEP  = PC_STEP_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] pc,
   output logic              misalign_err
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   logic [ADDR_W-1:0] pc_next;

   // Flush overrides stall; increment wraps naturally at the address width.
   always_comb begin
      pc_next = pc;
      if (redirect_valid)
         pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (!stall)
         pc_next = pc + STEP;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_PC;
         misalign_err <= 1'b0;
      end else begin
         pc           <= pc_next;
         misalign_err <= redirect_valid & (|redirect_pc[1:0]);
      end
   end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
//==============================================================================
// if_stage: instruction fetch stage driving insmem and loading the IF/ID
// register, with stall, redirect flush and delivered-instruction counter. Rev 1.0
//==============================================================================
`default_nettype none

module if_stage
   import riscv_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INSTR_W  = INSTR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = PC_STEP_DEF,
   parameter int                CNT_W    = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               ifid_valid,
   output logic [ADDR_W-1:0]  ifid_pc,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [6:0]         ifid_opcode,
   output logic               misalign_err,
   output logic [CNT_W-1:0]   fetch_count
);

   localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

   logic [ADDR_W-1:0] pc;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .PC_STEP  (PC_STEP),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc             (pc),
      .misalign_err   (misalign_err)
   );

   // insmem reads asynchronously, so the word for pc is available this cycle.
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_valid  <= 1'b0;
         ifid_pc     <= '0;
         ifid_instr  <= NOP;
         ifid_opcode <= opcode_of(NOP_INSTR);
         fetch_count <= '0;
      end else if (redirect_valid) begin
         ifid_valid  <= 1'b0;
         ifid_instr  <= NOP;
         ifid_opcode <= opcode_of(NOP_INSTR);
      end else if (!stall) begin
         ifid_valid  <= 1'b1;
         ifid_pc     <= pc;
         ifid_instr  <= imem_instr;
         ifid_opcode <= imem_instr[OPCODE_MSB:OPCODE_LSB];
         if (!(&fetch_count))
            fetch_count <= fetch_count + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test of if_stage against a combinational insmem model,
// plus a 2-bit-counter instance sharing the same stimulus for saturation.
`default_nettype none

module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;

   logic [7:0]  imem_addr,  imem_addr2;
   logic [31:0] imem_instr, imem_instr2;
   logic        ifid_valid, ifid_valid2;
   logic [7:0]  ifid_pc,    ifid_pc2;
   logic [31:0] ifid_instr, ifid_instr2;
   logic [6:0]  ifid_opcode, ifid_opcode2;
   logic        misalign_err, misalign_err2;
   logic [15:0] fetch_count;
   logic [1:0]  fetch_count2;

   logic [31:0] mem [64];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_instr  = mem[imem_addr[7:2]];
   assign imem_instr2 = mem[imem_addr2[7:2]];

   if_stage dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
      .ifid_opcode(ifid_opcode), .misalign_err(misalign_err),
      .fetch_count(fetch_count)
   );

   if_stage #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ifid_valid(ifid_valid2), .ifid_pc(ifid_pc2), .ifid_instr(ifid_instr2),
      .ifid_opcode(ifid_opcode2), .misalign_err(misalign_err2),
      .fetch_count(fetch_count2)
   );

   // Distinct word per address; low byte equals the address so opcodes vary.
   function automatic logic [31:0] word_at(input logic [7:0] a);
      return {16'hBEEF, 2'b00, a[7:2], a};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic v, input logic [7:0] pc,
                             input logic [31:0] instr, input logic [15:0] cnt);
      check({tag, "_valid"}, 32'(ifid_valid), 32'(v));
      check({tag, "_pc"},    32'(ifid_pc),    32'(pc));
      check({tag, "_instr"}, ifid_instr,      instr);
      check({tag, "_opc"},   32'(ifid_opcode), 32'(instr[6:0]));
      check({tag, "_cnt"},   32'(fetch_count), 32'(cnt));
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = word_at(8'(i * 4));
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;

      // 1: reset and sequential fetch
      step(); step();
      check_ifid("rst", 1'b0, 8'h00, 32'h0000_0013, 16'd0);
      check("rst_addr", 32'(imem_addr), 32'h00);
      check("rst_mis", 32'(misalign_err), 32'h0);
      check("rst_cnt2", 32'(fetch_count2), 32'h0);
      rst = 1'b0;
      #1;
      check("rel_addr", 32'(imem_addr), 32'h00);
      check("rel_valid", 32'(ifid_valid), 32'h0);
      step();
      check_ifid("seq0", 1'b1, 8'h00, word_at(8'h00), 16'd1);
      check("seq0_addr", 32'(imem_addr), 32'h04);
      step();
      check_ifid("seq1", 1'b1, 8'h04, word_at(8'h04), 16'd2);
      check("seq1_addr", 32'(imem_addr), 32'h08);

      // 2: stall at pc=08
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_ifid("stall", 1'b1, 8'h04, word_at(8'h04), 16'd2);
         check("stall_addr", 32'(imem_addr), 32'h08);
      end
      stall = 1'b0;
      step();
      check_ifid("unstall", 1'b1, 8'h08, word_at(8'h08), 16'd3);
      check("unstall_addr", 32'(imem_addr), 32'h0C);
      check("sat_cnt2_a", 32'(fetch_count2), 32'd3);

      // 3: redirect overrides stall
      redirect_valid = 1'b1; redirect_pc = 8'h40; stall = 1'b1;
      step();
      check_ifid("redir", 1'b0, 8'h08, 32'h0000_0013, 16'd3);
      check("redir_addr", 32'(imem_addr), 32'h40);
      check("redir_mis", 32'(misalign_err), 32'h0);
      redirect_valid = 1'b0; stall = 1'b0;
      step();
      check_ifid("redir1", 1'b1, 8'h40, word_at(8'h40), 16'd4);
      check("redir1_addr", 32'(imem_addr), 32'h44);

      // 4: misaligned target is aligned down, one-cycle error pulse
      redirect_valid = 1'b1; redirect_pc = 8'h42;
      step();
      check("mis_addr", 32'(imem_addr), 32'h40);
      check("mis_pulse", 32'(misalign_err), 32'h1);
      check("mis_valid", 32'(ifid_valid), 32'h0);
      redirect_valid = 1'b0;
      step();
      check("mis_clear", 32'(misalign_err), 32'h0);
      check_ifid("mis1", 1'b1, 8'h40, word_at(8'h40), 16'd5);
      check("mis1_addr", 32'(imem_addr), 32'h44);

      // 5: wrap from FC to 00
      redirect_valid = 1'b1; redirect_pc = 8'hFC;
      step();
      check("wrap_addr0", 32'(imem_addr), 32'hFC);
      redirect_valid = 1'b0;
      step();
      check_ifid("wrapFC", 1'b1, 8'hFC, word_at(8'hFC), 16'd6);
      check("wrap_addr1", 32'(imem_addr), 32'h00);
      step();
      check_ifid("wrap00", 1'b1, 8'h00, word_at(8'h00), 16'd7);
      check("wrap_addr2", 32'(imem_addr), 32'h04);
      check("sat_cnt2_b", 32'(fetch_count2), 32'd3);

      // 6: mid-stream reset at pc=10
      step(); step(); step();
      check("pre_rst_addr", 32'(imem_addr), 32'h10);
      check("pre_rst_valid", 32'(ifid_valid), 32'h1);
      rst = 1'b1;
      step();
      check_ifid("mrst", 1'b0, 8'h00, 32'h0000_0013, 16'd0);
      check("mrst_addr", 32'(imem_addr), 32'h00);
      check("mrst_cnt2", 32'(fetch_count2), 32'd0);
      rst = 1'b0;
      step();
      check_ifid("post", 1'b1, 8'h00, word_at(8'h00), 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
